// File: rtl/video_axis_pkg.sv
// Shared types and helpers for the video-to-AXI4-Stream packer.
package video_axis_pkg;

  localparam int PIXEL_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    DROP
  } packer_state_t;

  typedef struct packed {
    logic               tuser;
    logic               tlast;
    logic [PIXEL_W-1:0] data;
  } fifo_word_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/axi4s_if.sv
// Minimal AXI4-Stream bundle carrying tdata/tvalid/tready/tlast/tuser.
interface axi4s_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; rd_data shows the head entry whenever !empty.
module sync_fifo_fwft
  import video_axis_pkg::*;
#(
  parameter int WIDTH = 18,
  parameter int DEPTH = 2048
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [clog2(DEPTH):0] level
);

  localparam int AW    = clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Upstream admission control must make this impossible.
  assert property (@(posedge clk) disable iff (rst) !(wr_en && full));

endmodule

// File: rtl/video_to_axis_packer.sv
// Packs a non-stallable de/vs pixel stream into AXI4-Stream, admitting only whole lines.
// Define VIDEO_TO_AXIS_PACKER_STATS_EN to add frame_cnt/drop_cnt statistics outputs.
module video_to_axis_packer
  import video_axis_pkg::*;
#(
  parameter int DATA_WIDTH = PIXEL_W,
  parameter int H_ACTIVE   = 640,
  parameter int FIFO_DEPTH = 2048
) (
  input  logic                       axi_clk,
  input  logic                       axi_rst,
  input  logic                       vid_de,
  input  logic                       vid_vs,
  input  logic [DATA_WIDTH-1:0]      vid_data,
  axi4s_if.master                    m_axis,
  output logic                       line_dropped,
  output logic                       line_len_err,
  output logic [clog2(FIFO_DEPTH):0] fifo_level
`ifdef VIDEO_TO_AXIS_PACKER_STATS_EN
  ,
  output logic [15:0]                frame_cnt,
  output logic [15:0]                drop_cnt
`endif
);

  // Counter saturates at H_ACTIVE+1 so over-long lines stay distinguishable.
  localparam int CNT_W = clog2(H_ACTIVE + 2);
  localparam logic [CNT_W-1:0] H_MAX = CNT_W'(H_ACTIVE);

  packer_state_t   state;
  logic            vs_q;
  logic            de_q;
  logic            vs_rise;
  logic            de_rise;
  logic            sof_pending;
  logic [CNT_W-1:0] pix_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic            room_ok;
  logic            admit;
  logic            take;
  logic            drop;

  logic                  hold_vld_p0;
  logic                  hold_sof_p0;
  logic                  hold_max_p0;
  logic [DATA_WIDTH-1:0] hold_data_p0;

  fifo_word_t wr_word;
  fifo_word_t rd_word;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_rd;

  assign vs_rise  = vid_vs & ~vs_q;
  assign de_rise  = vid_de & ~de_q;
  assign room_ok  = ~fifo_full &
                    ((32'(fifo_level) + 32'(hold_vld_p0) + 32'(H_ACTIVE)) <= 32'(FIFO_DEPTH));
  assign admit    = (state == IDLE) & de_rise & room_ok;
  assign drop     = (state == IDLE) & de_rise & ~room_ok;
  assign take     = (state == ACCEPT) & vid_de & (pix_cnt < H_MAX);
  assign cnt_next = admit ? CNT_W'(1) : pix_cnt + 1'b1;

  // Edge registers reset high so a line or frame already in progress at
  // reset release is ignored until its next genuine rising edge.
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      vs_q         <= 1'b1;
      de_q         <= 1'b1;
      state        <= IDLE;
      sof_pending  <= 1'b0;
      pix_cnt      <= '0;
      hold_vld_p0  <= 1'b0;
      hold_sof_p0  <= 1'b0;
      hold_max_p0  <= 1'b0;
      line_dropped <= 1'b0;
      line_len_err <= 1'b0;
    end else begin
      vs_q         <= vid_vs;
      de_q         <= vid_de;
      line_dropped <= 1'b0;
      line_len_err <= 1'b0;
      hold_vld_p0  <= admit | take;
      if (admit | take) begin
        hold_sof_p0 <= admit & sof_pending;
        hold_max_p0 <= (cnt_next == H_MAX);
      end

      case (state)
        IDLE: begin
          if (admit) begin
            state       <= ACCEPT;
            pix_cnt     <= cnt_next;
            sof_pending <= 1'b0;
          end else if (drop) begin
            state        <= DROP;
            line_dropped <= 1'b1;
          end
        end
        ACCEPT: begin
          if (vid_de) begin
            if (pix_cnt <= H_MAX) pix_cnt <= cnt_next;
          end else begin
            state        <= IDLE;
            line_len_err <= (pix_cnt != H_MAX);
          end
        end
        DROP: begin
          if (!vid_de) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (vs_rise) sof_pending <= 1'b1;
    end
  end

  always_ff @(posedge axi_clk) begin
    if (admit | take) hold_data_p0 <= vid_data;
  end

  // ---- p0 -> FIFO: tlast resolved once the following cycle's de is known ----
  always_comb begin
    wr_word.tuser = hold_sof_p0;
    wr_word.tlast = hold_max_p0 | ~vid_de;
    wr_word.data  = hold_data_p0;
  end

  sync_fifo_fwft #(
    .WIDTH($bits(fifo_word_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (axi_clk),
    .rst    (axi_rst),
    .wr_en  (hold_vld_p0),
    .wr_data(wr_word),
    .rd_en  (fifo_rd),
    .rd_data(rd_word),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  // ---- FIFO -> stream ----
  assign fifo_rd       = ~fifo_empty & m_axis.tready;
  assign m_axis.tvalid = ~fifo_empty;
  assign m_axis.tdata  = rd_word.data;
  assign m_axis.tlast  = ~fifo_empty & rd_word.tlast;
  assign m_axis.tuser  = ~fifo_empty & rd_word.tuser;

`ifdef VIDEO_TO_AXIS_PACKER_STATS_EN
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (vs_rise) frame_cnt <= frame_cnt + 16'd1;
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_video_to_axis_packer.sv
// Scoreboard bench for video_to_axis_packer: expected beats queued at stimulus time, popped on handshake.
module tb_video_to_axis_packer;

  localparam int DW = 16;
  localparam int HA = 640;
  localparam int FD = 2048;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vid_de = 1'b0;
  logic          vid_vs = 1'b0;
  logic [DW-1:0] vid_data = '0;
  logic          line_dropped;
  logic          line_len_err;
  logic [11:0]   fifo_level;
`ifdef VIDEO_TO_AXIS_PACKER_STATS_EN
  logic [15:0]   frame_cnt;
  logic [15:0]   drop_cnt;
`endif

  axi4s_if #(.DATA_WIDTH(DW)) m_if ();

  always #5 clk = ~clk;

  video_to_axis_packer #(
    .DATA_WIDTH(DW),
    .H_ACTIVE  (HA),
    .FIFO_DEPTH(FD)
  ) dut (
    .axi_clk     (clk),
    .axi_rst     (rst),
    .vid_de      (vid_de),
    .vid_vs      (vid_vs),
    .vid_data    (vid_data),
    .m_axis      (m_if),
    .line_dropped(line_dropped),
    .line_len_err(line_len_err),
    .fifo_level  (fifo_level)
`ifdef VIDEO_TO_AXIS_PACKER_STATS_EN
    ,
    .frame_cnt   (frame_cnt),
    .drop_cnt    (drop_cnt)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;
  int beats = 0;
  int drops_seen = 0;
  int lenerr_seen = 0;
  int ready_mode = 0;  // 0: low, 1: high, 2: one cycle in four
  int cyc = 0;
  bit sof_exp = 1'b0;
  logic [DW+1:0] sb[$];

  // tready driver, updated just after each rising edge
  initial begin
    m_if.tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (ready_mode)
        1:       m_if.tready = 1'b1;
        2:       m_if.tready = (cyc % 4 == 0);
        default: m_if.tready = 1'b0;
      endcase
    end
  end

  // Output monitor: scoreboard pops and stall-stability checks
  logic          prev_stall = 1'b0;
  logic [DW+1:0] prev_word = '0;
  always @(negedge clk) begin
    logic [DW+1:0] w;
    logic [DW+1:0] e;
    w = {m_if.tuser, m_if.tlast, m_if.tdata};
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (line_dropped) drops_seen++;
      if (line_len_err) lenerr_seen++;
      if (prev_stall) begin
        n_chk++;
        if (!m_if.tvalid || w !== prev_word)
          $display("FAIL stall_hold t=%0t got vld=%0b word=%h want vld=1 word=%h", $time, m_if.tvalid, w, prev_word);
        else n_pass++;
      end
      if (m_if.tvalid && m_if.tready) begin
        beats++;
        n_chk++;
        if (sb.size() == 0) begin
          $display("FAIL beat_unexpected t=%0t got word=%h want none", $time, w);
        end else begin
          e = sb.pop_front();
          if (w !== e) $display("FAIL beat t=%0t got {tuser,tlast,data}=%h want %h", $time, w, e);
          else n_pass++;
        end
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_word  = w;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_vs();
    step();
    vid_vs = 1'b1;
    repeat (3) step();
    vid_vs = 1'b0;
    sof_exp = 1'b1;
    repeat (2) step();
  endtask

  // Drive one line of n pixels then blanking; queue expected beats if it should be admitted.
  task automatic drive_line(input int n, input int base, input bit admit, input int blank);
    int k;
    logic [DW+1:0] w;
    k = (n < HA) ? n : HA;
    if (admit) begin
      for (int i = 0; i < k; i++) begin
        w = {1'b0, 1'b0, DW'(base + i)};
        w[DW+1] = (i == 0) && sof_exp;
        w[DW]   = (i == k - 1);
        sb.push_back(w);
      end
      sof_exp = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      step();
      vid_de   = 1'b1;
      vid_data = DW'(base + i);
    end
    for (int i = 0; i < blank; i++) begin
      step();
      vid_de = 1'b0;
    end
  endtask

  task automatic drain(input int budget, output bit timed_out);
    for (int c = 0; c < budget && sb.size() != 0; c++) step();
    repeat (4) step();
    timed_out = (sb.size() != 0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_chk++; if (m_if.tvalid !== 1'b0) $display("FAIL rst_tvalid got %b want 0", m_if.tvalid); else n_pass++;
    n_chk++; if (m_if.tlast !== 1'b0) $display("FAIL rst_tlast got %b want 0", m_if.tlast); else n_pass++;
    n_chk++; if (m_if.tuser !== 1'b0) $display("FAIL rst_tuser got %b want 0", m_if.tuser); else n_pass++;
    n_chk++; if (line_dropped !== 1'b0) $display("FAIL rst_line_dropped got %b want 0", line_dropped); else n_pass++;
    n_chk++; if (line_len_err !== 1'b0) $display("FAIL rst_line_len_err got %b want 0", line_len_err); else n_pass++;
    n_chk++; if (fifo_level !== 12'd0) $display("FAIL rst_fifo_level got %0d want 0", fifo_level); else n_pass++;
`ifdef VIDEO_TO_AXIS_PACKER_STATS_EN
    n_chk++; if (frame_cnt !== 16'd0) $display("FAIL rst_frame_cnt got %0d want 0", frame_cnt); else n_pass++;
    n_chk++; if (drop_cnt !== 16'd0) $display("FAIL rst_drop_cnt got %0d want 0", drop_cnt); else n_pass++;
`endif
    step();
    rst = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_nominal();
    int b0, d0, e0;
    bit to;
    b0 = beats; d0 = drops_seen; e0 = lenerr_seen;
    ready_mode = 1;
    do_vs();
    for (int l = 0; l < 4; l++) drive_line(HA, l * 1000, 1'b1, 160);
    drain(3000, to);
    n_chk++; if (to) $display("FAIL nominal_drain left=%0d want 0", sb.size()); else n_pass++;
    n_chk++; if (beats - b0 != 2560) $display("FAIL nominal_beats got %0d want 2560", beats - b0); else n_pass++;
    n_chk++; if (drops_seen - d0 != 0) $display("FAIL nominal_drops got %0d want 0", drops_seen - d0); else n_pass++;
    n_chk++; if (lenerr_seen - e0 != 0) $display("FAIL nominal_lenerr got %0d want 0", lenerr_seen - e0); else n_pass++;
  endtask

  task automatic test_short_line();
    int b0, e0;
    bit to;
    b0 = beats; e0 = lenerr_seen;
    ready_mode = 1;
    drive_line(100, 10000, 1'b1, 160);
    drive_line(HA, 11000, 1'b1, 160);
    drain(2000, to);
    n_chk++; if (to) $display("FAIL short_drain left=%0d want 0", sb.size()); else n_pass++;
    n_chk++; if (beats - b0 != 740) $display("FAIL short_beats got %0d want 740", beats - b0); else n_pass++;
    n_chk++; if (lenerr_seen - e0 != 1) $display("FAIL short_lenerr got %0d want 1", lenerr_seen - e0); else n_pass++;
  endtask

  task automatic test_long_line();
    int b0, e0;
    bit to;
    b0 = beats; e0 = lenerr_seen;
    ready_mode = 1;
    drive_line(700, 20000, 1'b1, 160);
    drain(2000, to);
    n_chk++; if (to) $display("FAIL long_drain left=%0d want 0", sb.size()); else n_pass++;
    n_chk++; if (beats - b0 != 640) $display("FAIL long_beats got %0d want 640", beats - b0); else n_pass++;
    n_chk++; if (lenerr_seen - e0 != 1) $display("FAIL long_lenerr got %0d want 1", lenerr_seen - e0); else n_pass++;
  endtask

  task automatic test_back_pressure();
    int b0, d0, e0;
    bit to;
    b0 = beats; d0 = drops_seen; e0 = lenerr_seen;
    ready_mode = 2;
    do_vs();
    for (int l = 0; l < 5; l++) drive_line(HA, 30000 + l * 1000, (l < 4), 160);
    ready_mode = 1;
    drain(4000, to);
    n_chk++; if (to) $display("FAIL bp_drain left=%0d want 0", sb.size()); else n_pass++;
    n_chk++; if (beats - b0 != 2560) $display("FAIL bp_beats got %0d want 2560", beats - b0); else n_pass++;
    n_chk++; if (drops_seen - d0 != 1) $display("FAIL bp_drops got %0d want 1", drops_seen - d0); else n_pass++;
    n_chk++; if (lenerr_seen - e0 != 0) $display("FAIL bp_lenerr got %0d want 0", lenerr_seen - e0); else n_pass++;
  endtask

  task automatic test_drop_first();
    int b0, d0;
    bit to;
    b0 = beats; d0 = drops_seen;
    ready_mode = 0;
    for (int l = 0; l < 3; l++) drive_line(HA, 40000 + l * 1000, 1'b1, 160);
    n_chk++; if (fifo_level !== 12'd1920) $display("FAIL df_level got %0d want 1920", fifo_level); else n_pass++;
    do_vs();
    drive_line(HA, 43000, 1'b0, 160);
    n_chk++; if (drops_seen - d0 != 1) $display("FAIL df_drops got %0d want 1", drops_seen - d0); else n_pass++;
    n_chk++; if (fifo_level !== 12'd1920) $display("FAIL df_level_after_drop got %0d want 1920", fifo_level); else n_pass++;
    ready_mode = 1;
    drain(3000, to);
    n_chk++; if (to) $display("FAIL df_drain1 left=%0d want 0", sb.size()); else n_pass++;
    drive_line(HA, 44000, 1'b1, 160);
    drain(2000, to);
    n_chk++; if (to) $display("FAIL df_drain2 left=%0d want 0", sb.size()); else n_pass++;
    n_chk++; if (beats - b0 != 2560) $display("FAIL df_beats got %0d want 2560", beats - b0); else n_pass++;
  endtask

  task automatic test_reset_midline();
    int b0, d0, e0;
    bit to;
    logic [DW+1:0] w;
    ready_mode = 1;
    for (int i = 0; i < 300; i++) begin
      w = {1'b0, 1'b0, DW'(50000 + i)};
      sb.push_back(w);
    end
    for (int i = 0; i < 300; i++) begin
      step();
      vid_de   = 1'b1;
      vid_data = DW'(50000 + i);
    end
    step();
    rst      = 1'b1;
    vid_data = DW'(50300);
    #1;
    sb.delete();
    n_chk++; if (m_if.tvalid !== 1'b0) $display("FAIL midrst_tvalid got %b want 0", m_if.tvalid); else n_pass++;
    n_chk++; if (fifo_level !== 12'd0) $display("FAIL midrst_level got %0d want 0", fifo_level); else n_pass++;
    for (int i = 301; i < 304; i++) begin
      step();
      vid_data = DW'(50000 + i);
    end
    rst = 1'b0;
    b0 = beats; d0 = drops_seen; e0 = lenerr_seen;
    for (int i = 304; i < HA; i++) begin
      step();
      vid_data = DW'(50000 + i);
    end
    for (int i = 0; i < 160; i++) begin
      step();
      vid_de = 1'b0;
    end
    drive_line(HA, 51000, 1'b1, 160);
    drain(2000, to);
    n_chk++; if (to) $display("FAIL midrst_drain left=%0d want 0", sb.size()); else n_pass++;
    n_chk++; if (beats - b0 != 640) $display("FAIL midrst_beats got %0d want 640", beats - b0); else n_pass++;
    n_chk++; if (lenerr_seen - e0 != 0) $display("FAIL midrst_lenerr got %0d want 0", lenerr_seen - e0); else n_pass++;
    n_chk++; if (drops_seen - d0 != 0) $display("FAIL midrst_drops got %0d want 0", drops_seen - d0); else n_pass++;
`ifdef VIDEO_TO_AXIS_PACKER_STATS_EN
    n_chk++; if (frame_cnt !== 16'd0) $display("FAIL midrst_frame_cnt got %0d want 0", frame_cnt); else n_pass++;
    n_chk++; if (drop_cnt !== 16'd0) $display("FAIL midrst_drop_cnt got %0d want 0", drop_cnt); else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_short_line();
    test_long_line();
    test_back_pressure();
    test_drop_first();
    test_reset_midline();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/video_to_axis_packer.md
Name: video_to_axis_packer

Overview:
- Upstream feeder for the SDRAM write path. Converts a free-running, non-stallable pixel stream (de/vs/data) into AXI4-Stream.
- Output framing: tuser marks start of frame, tlast marks end of line, so each SDRAM write burst chain ends on a line boundary.
- Buffers pixels in a single-clock FIFO.
- Admits a line only if the whole line fits, so partial lines never reach SDRAM.

Parameters:
- DATA_WIDTH, 16, pixel and tdata width
- H_ACTIVE, 640, nominal pixels per line; maximum line length forwarded
- FIFO_DEPTH, 2048, FIFO entries (power of two, >= 2*H_ACTIVE)

Ports:
- axi_clk  input  1  single clock for pixel side and stream side
- axi_rst  input  1  asynchronous, active-high reset
- vid_de  input  1  pixel valid (data enable); cannot be back-pressured
- vid_vs  input  1  vertical sync; a rising edge marks a new frame
- vid_data  input  DATA_WIDTH  pixel
- m_axis  axi4s_if.master  -  tdata[DATA_WIDTH-1:0], tvalid, tready, tlast, tuser
- line_dropped  output  1  one-cycle pulse when a line is rejected at admission
- line_len_err  output  1  one-cycle pulse when a line ends with length != H_ACTIVE
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset values: m_axis.tvalid=0, tlast=0, tuser=0, line_dropped=0, line_len_err=0, fifo_level=0, FSM=IDLE, sof_pending=0, pixel counter=0, hold register empty.
- Edge detection: vs_q and de_q registers. A vs rising edge sets sof_pending. A de rising edge is a line start.
- FSM states:
  - IDLE: on line start, if free space >= H_ACTIVE, go to ACCEPT and write the pixel. Otherwise go to DROP and pulse line_dropped.
  - ACCEPT: write pixels while de=1 and count < H_ACTIVE. Pixels beyond H_ACTIVE are discarded. On the de falling edge, go to IDLE.
  - DROP: discard all pixels until the de falling edge, then go to IDLE. sof_pending is kept, so tuser moves to the next admitted line.
- tlast deferral: each accepted pixel waits one cycle in a hold register before entering the FIFO.
  - It is written with tlast=1 if the next cycle has de=0, or if it is pixel number H_ACTIVE.
  - FIFO entry format is {tuser, tlast, data}.
  - A short line therefore still ends with tlast on its last real pixel.
- tuser: set on the first admitted pixel after sof_pending; that write clears sof_pending.
- line_len_err: pulses one cycle after the de falling edge when the accepted count differs from H_ACTIVE (both short and long lines). Not asserted for dropped lines.
- Output side: first-word-fall-through. tvalid = !empty. A pop happens on tvalid && tready. tdata/tlast/tuser stay stable while tvalid && !tready.
- Latency: a pixel first appears on m_axis at earliest 2 cycles after sampling (hold register, then FIFO write and FWFT).
- Admission guarantees the FIFO never overflows; a write while full is an assertion failure in simulation.
- Simultaneous push and pop in one cycle: fifo_level is unchanged.
- vs rising during ACCEPT: the current line completes normally; the next admitted line carries tuser.
- Asynchronous reset mid-line: the FIFO empties, and output resumes at the next line start after reset release with a clean tuser/tlast structure.

Optional Feature:
- Macro: VIDEO_TO_AXIS_PACKER_STATS_EN.
- When defined, adds:
  - output frame_cnt[15:0]: counts vs rising edges, wraps at 0xFFFF->0.
  - output drop_cnt[15:0]: counts rejected lines, saturates at 0xFFFF.
  - Both reset to 0.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package video_axis_pkg:
  - packer_state_t enum {IDLE, ACCEPT, DROP}
  - fifo_word_t packed struct {tuser, tlast, data}
  - function clog2 helper for the fifo_level width
- Sub-module sync_fifo_fwft: single-clock, parameterised width and depth, FWFT, with outputs full/empty/level. The packer FSM, edge detect and hold register stay in the top module.

Test Plan:
- Nominal frame: vs pulse, then 4 lines of 640 pixels (data = line*1000+index), tready=1 -> 2560 beats; tuser only on beat 0; tlast on every 640th beat; data in order; no error pulses.
- Back-pressure: tready toggles 1 cycle on / 3 off, FIFO_DEPTH=2048, lines of 640 with 160-cycle blanking -> line 4 rejected (line_dropped pulse, no beats from it); output beats stay stable while stalled; every delivered line is exactly 640 beats ending in tlast.
- Short line of 100 pixels -> 100 beats, tlast on beat 99, one line_len_err pulse; the following 640-pixel line is clean.
- Long line of 700 pixels -> 640 beats with tlast on beat 639; pixels 640..699 absent; line_len_err pulse.
- Dropped first line after vs: tready=0 until FIFO free < 640, then start a frame -> line dropped; the first admitted line carries tuser=1.
- Reset asserted mid-line at pixel 300 -> tvalid=0 and fifo_level=0 in the same cycle; after release, the next line delivers 640 beats; with VIDEO_TO_AXIS_PACKER_STATS_EN defined, frame_cnt and drop_cnt read 0.
